// File: rtl/dmem_access.sv
// MEM-stage data-memory access unit: alignment check, store lane steering,
// and a single-outstanding req/addr_ok/data_ok bus master that stalls the
// pipeline until the access completes and then holds the raw read word.
module dmem_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [2:0]        ls_type_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  input  logic              adv_i,
  output logic              laddrerr_o,
  output logic              saddrerr_o,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_CANCEL = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              data_req_q, data_req_d;
  logic              data_wr_q, data_wr_d;
  logic [1:0]        data_size_q, data_size_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [3:0]        data_wstrb_q, data_wstrb_d;
  logic [31:0]       data_wdata_q, data_wdata_d;

  logic        is_load, is_half, is_word, misalign, start;
  logic [1:0]  size_w;
  logic [3:0]  wstrb_w;
  logic [31:0] wdata_w;

  // Decode access width, alignment and the store lane/replication pattern.
  always_comb begin
    is_load  = (ls_type_i <= 3'd4);
    is_half  = (ls_type_i == 3'd2) || (ls_type_i == 3'd3) || (ls_type_i == 3'd6);
    is_word  = (ls_type_i == 3'd4) || (ls_type_i == 3'd7);
    misalign = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
    laddrerr_o = en_i && is_load && misalign;
    saddrerr_o = en_i && !is_load && misalign;
    start      = en_i && !flush_i && !laddrerr_o && !saddrerr_o;
    size_w   = is_word ? 2'd2 : (is_half ? 2'd1 : 2'd0);
    wstrb_w  = 4'b0000;
    wdata_w  = 32'h0;
    if (!is_load) begin
      case (size_w)
        2'd0: begin
          wstrb_w = 4'b0001 << addr_i[1:0];
          wdata_w = {4{wdata_i[7:0]}};
        end
        2'd1: begin
          wstrb_w = addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_w = {2{wdata_i[15:0]}};
        end
        default: begin
          wstrb_w = 4'b1111;
          wdata_w = wdata_i;
        end
      endcase
    end
  end

  // Bus FSM next state, stall, and bus field latching on IDLE->REQ.
  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    data_req_d   = data_req_q;
    data_wr_d    = data_wr_q;
    data_size_d  = data_size_q;
    data_addr_d  = data_addr_q;
    data_wstrb_d = data_wstrb_q;
    data_wdata_d = data_wdata_q;
    stall_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o = start;
        if (start) begin
          state_d      = S_REQ;
          data_req_d   = 1'b1;
          data_wr_d    = !is_load;
          data_size_d  = size_w;
          data_addr_d  = addr_i;
          data_wstrb_d = wstrb_w;
          data_wdata_d = wdata_w;
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        // A same-cycle data_ok is illegal on this bus; only addr_ok counts here.
        if (data_addr_ok) begin
          data_req_d = 1'b0;
          state_d    = flush_i ? S_CANCEL : S_WAIT;
        end else if (flush_i) begin
          data_req_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (data_data_ok) begin
          if (flush_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (!data_wr_q) rdata_d = data_rdata;
          end
        end else if (flush_i) begin
          state_d = S_CANCEL;
        end
      end
      S_DONE: begin
        if (adv_i || flush_i) state_d = S_IDLE;
      end
      S_CANCEL: begin
        // The killed access still owes a response; swallow it before reissuing.
        stall_o = en_i;
        if (data_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered bus outputs; async reset drops any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rdata_q      <= 32'h0;
      data_req_q   <= 1'b0;
      data_wr_q    <= 1'b0;
      data_size_q  <= 2'd0;
      data_addr_q  <= '0;
      data_wstrb_q <= 4'b0000;
      data_wdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      rdata_q      <= rdata_d;
      data_req_q   <= data_req_d;
      data_wr_q    <= data_wr_d;
      data_size_q  <= data_size_d;
      data_addr_q  <= data_addr_d;
      data_wstrb_q <= data_wstrb_d;
      data_wdata_q <= data_wdata_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign data_req   = data_req_q;
  assign data_wr    = data_wr_q;
  assign data_size  = data_size_q;
  assign data_addr  = data_addr_q;
  assign data_wstrb = data_wstrb_q;
  assign data_wdata = data_wdata_q;

endmodule

// File: tb/tb_dmem_access.sv
// Bench for dmem_access: directed scenarios plus randomized accesses, with
// the bench playing the bus slave and predicting results from access rules.
module tb_dmem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic [2:0]  ls_type_i;
  logic [31:0] addr_i, wdata_i;
  logic        flush_i, adv_i;
  logic        laddrerr_o, saddrerr_o, stall_o;
  logic [31:0] rdata_o;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rdata = 32'h0;

  dmem_access #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .ls_type_i(ls_type_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .flush_i(flush_i), .adv_i(adv_i),
    .laddrerr_o(laddrerr_o), .saddrerr_o(saddrerr_o), .stall_o(stall_o),
    .rdata_o(rdata_o), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full access; entered and left just after a falling edge. aw/dw are
  // bus wait cycles before addr_ok/data_ok, hold is DONE cycles with adv_i=0.
  task automatic access(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rv, input int aw, input int dw, input int hold);
    int          nb;
    logic        ld, err;
    logic [3:0]  es;
    logic [31:0] ew;
    logic [1:0]  esz;
    ld  = (t <= 3'd4);
    nb  = (t == 3'd4 || t == 3'd7) ? 4 : ((t == 3'd2 || t == 3'd3 || t == 3'd6) ? 2 : 1);
    esz = (nb == 4) ? 2'd2 : ((nb == 2) ? 2'd1 : 2'd0);
    err = (a % nb) != 0;
    if (ld) es = 4'b0000;
    else if (nb == 4) es = 4'b1111;
    else if (nb == 2) es = 4'b0011 << (a % 4);
    else es = 4'b0001 << (a % 4);
    if (nb == 1) ew = {24'h0, wd[7:0]} * 32'h01010101;
    else if (nb == 2) ew = {16'h0, wd[15:0]} * 32'h00010001;
    else ew = wd;

    en_i = 1'b1; ls_type_i = t; addr_i = a; wdata_i = wd;
    flush_i = 1'b0; adv_i = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    check("laddrerr", {31'h0, laddrerr_o}, {31'h0, ld && err});
    check("saddrerr", {31'h0, saddrerr_o}, {31'h0, !ld && err});
    check("stall_c0", {31'h0, stall_o}, {31'h0, !err});
    if (err) begin
      @(negedge clk);
      check("err_noreq", {31'h0, data_req}, 32'h0);
      check("err_nostall", {31'h0, stall_o}, 32'h0);
      en_i = 1'b0;
      return;
    end
    for (int k = 0; k <= aw; k++) begin
      @(negedge clk);
      check("req", {31'h0, data_req}, 32'h1);
      check("req_stall", {31'h0, stall_o}, 32'h1);
      check("addr", data_addr, a);
      check("size", {30'h0, data_size}, {30'h0, esz});
      check("wstrb", {28'h0, data_wstrb}, {28'h0, es});
      check("wr", {31'h0, data_wr}, {31'h0, !ld});
      if (!ld) check("wdata", data_wdata, ew);
      data_addr_ok = (k == aw);
    end
    for (int k = 0; k <= dw; k++) begin
      @(negedge clk);
      data_addr_ok = 1'b0;
      check("wait_noreq", {31'h0, data_req}, 32'h0);
      check("wait_stall", {31'h0, stall_o}, 32'h1);
      data_data_ok = (k == dw);
      data_rdata   = (k == dw) ? rv : $urandom;
    end
    @(negedge clk);
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
    if (ld) exp_rdata = rv;
    check("done_stall", {31'h0, stall_o}, 32'h0);
    check("done_rdata", rdata_o, exp_rdata);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_stall", {31'h0, stall_o}, 32'h0);
      check("hold_noreq", {31'h0, data_req}, 32'h0);
      check("hold_rdata", rdata_o, exp_rdata);
    end
    adv_i = 1'b1;
    en_i  = 1'b0;
    @(negedge clk);
    adv_i = 1'b0;
    check("idle_noreq", {31'h0, data_req}, 32'h0);
    check("idle_stall", {31'h0, stall_o}, 32'h0);
    check("idle_rdata", rdata_o, exp_rdata);
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b0; ls_type_i = 3'd0; addr_i = 32'h0; wdata_i = 32'h0;
    flush_i = 1'b0; adv_i = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    data_rdata = 32'h0;
    @(negedge clk); @(negedge clk);
    check("rst_req", {31'h0, data_req}, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_addr", data_addr, 32'h0);
    check("rst_wstrb", {28'h0, data_wstrb}, 32'h0);
    check("rst_wdata", data_wdata, 32'h0);
    check("rst_misc", {29'h0, data_wr, data_size}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait LW, then SB/SH lane steering and misaligned cases.
    access(3'd4, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    access(3'd5, 32'h1003, 32'h000000A5, 32'h0, 0, 0, 0);
    access(3'd6, 32'h2002, 32'h1234ABCD, 32'h0, 1, 0, 0);
    access(3'd6, 32'h2001, 32'h1234ABCD, 32'h0, 0, 0, 0);
    access(3'd2, 32'h3003, 32'h0, 32'h0, 0, 0, 0);

    // Misaligned load under flush: still flagged, no request, no stall.
    en_i = 1'b1; ls_type_i = 3'd2; addr_i = 32'h3003; flush_i = 1'b1;
    #1;
    check("flush_lerr", {31'h0, laddrerr_o}, 32'h1);
    check("flush_err_stall", {31'h0, stall_o}, 32'h0);
    @(negedge clk);
    check("flush_err_noreq", {31'h0, data_req}, 32'h0);
    addr_i = 32'h3000;
    #1;
    check("flush_ok_stall", {31'h0, stall_o}, 32'h0);
    @(negedge clk);
    check("flush_ok_noreq", {31'h0, data_req}, 32'h0);
    en_i = 1'b0; flush_i = 1'b0;

    // Slow bus with outer stall in DONE.
    access(3'd4, 32'h1800, 32'h0, 32'hCAFEF00D, 3, 2, 2);

    // Flush while waiting for addr_ok: request withdrawn.
    en_i = 1'b1; ls_type_i = 3'd4; addr_i = 32'h5000;
    @(negedge clk);
    check("fr_req", {31'h0, data_req}, 32'h1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; en_i = 1'b0;
    #1;
    check("fr_dropped", {31'h0, data_req}, 32'h0);
    check("fr_stall", {31'h0, stall_o}, 32'h0);
    @(negedge clk);

    // Flush in WAIT then a new LW: stale data_ok swallowed in CANCEL.
    en_i = 1'b1; ls_type_i = 3'd4; addr_i = 32'h4000;
    @(negedge clk);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; flush_i = 1'b1;
    check("fw_stall", {31'h0, stall_o}, 32'h1);
    @(negedge clk);
    flush_i = 1'b0; addr_i = 32'h4100;
    #1;
    check("cancel_stall", {31'h0, stall_o}, 32'h1);
    check("cancel_noreq", {31'h0, data_req}, 32'h0);
    data_data_ok = 1'b1; data_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    data_data_ok = 1'b0;
    check("cancel_rdata", rdata_o, exp_rdata);
    check("cancel_idle_noreq", {31'h0, data_req}, 32'h0);
    access(3'd4, 32'h4100, 32'h0, 32'h600DF00D, 0, 1, 0);

    // Randomized accesses, biased toward aligned addresses.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 2) != 0) ra = ra & 32'hFFFF_FFFC | ({30'h0, 2'($urandom_range(0, 3))} & 32'h2);
      access(3'($urandom_range(0, 7)), ra, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset in the middle of a request: everything back to reset values.
    en_i = 1'b1; ls_type_i = 3'd4; addr_i = 32'h7000;
    @(negedge clk);
    check("mid_req", {31'h0, data_req}, 32'h1);
    rst = 1'b1; en_i = 1'b0;
    #1;
    check("mid_rst_req", {31'h0, data_req}, 32'h0);
    check("mid_rst_rdata", rdata_o, 32'h0);
    check("mid_rst_addr", data_addr, 32'h0);
    exp_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    data_data_ok = 1'b1; data_rdata = 32'h1111_2222;
    @(negedge clk);
    data_data_ok = 1'b0;
    check("post_rst_rdata", rdata_o, 32'h0);
    check("post_rst_noreq", {31'h0, data_req}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a wedged run.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
